ram_read_scanner: RTL and testbench



---
 rtl/ram_scan_pkg.sv | 14 +
 rtl/tick_divider.sv | 27 ++
 rtl/ram_read_scanner.sv | 119 +++++++++++
 tb/tb_ram_read_scanner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
// rtl/ram_scan_pkg.sv - shared defaults and FSM state type for the RAM read scanner
package ram_scan_pkg;

  localparam int SCAN_ADDR_W = 5;
  localparam int SCAN_DATA_W = 3;
  localparam int SCAN_RD_LAT = 2;

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } scan_state_t;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - enabled modulo-TICK_DIV counter with a one-cycle terminal tick
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             at_end;

  assign at_end = (cnt == CNT_W'(TICK_DIV - 1));
  assign tick   = enable && at_end;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= at_end ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_read_scanner.sv
// rtl/ram_read_scanner.sv - steps the RAM read port, waits out read latency, presents addr/data to the display
// RAM_SCAN_REFRESH_ON_WRITE_EN: re-read the displayed word when the write path hits it.
module ram_read_scanner
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W   = SCAN_ADDR_W,
  parameter int DATA_W   = SCAN_DATA_W,
  parameter int TICK_DIV = 50_000_000,
  parameter int RD_LAT   = SCAN_RD_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              step,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [DATA_W-1:0] cur_data,
  output logic              data_valid,
  output logic              wrapped
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  scan_state_t      state;
  scan_state_t      state_next;
  logic [LAT_W-1:0] lat_cnt;
  logic             pending;
  logic             tick;
  logic             addr_match;
  logic             lat_done;
  logic             advance;
  logic             refresh;

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_divider (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .tick   (tick)
  );

`ifdef RAM_SCAN_REFRESH_ON_WRITE_EN
  assign addr_match = wren && (wraddress == rd_addr);
`else
  logic unused_snoop;
  assign addr_match   = 1'b0;
  assign unused_snoop = ^{wren, wraddress};
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_WAIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:    state_next = lat_done ? S_CAPTURE : S_WAIT;
      S_CAPTURE: state_next = S_HOLD;
      S_HOLD:    state_next = (advance || refresh) ? S_WAIT : S_HOLD;
      default:   state_next = S_WAIT;
    endcase
  end

  // An advance always beats a refresh; both restart the latency wait.
  always_comb begin
    lat_done = (state == S_WAIT) && (lat_cnt == LAT_W'(RD_LAT - 1));
    advance  = (state == S_HOLD) && (tick || step);
    refresh  = (state == S_HOLD) && !advance && (pending || addr_match);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_cnt    <= '0;
      rd_addr    <= '0;
      cur_addr   <= '0;
      cur_data   <= '0;
      data_valid <= 1'b0;
      wrapped    <= 1'b0;
      pending    <= 1'b0;
    end else begin
      data_valid <= (state == S_CAPTURE);
      wrapped    <= advance && (rd_addr == '1);

      if (advance || refresh) begin
        lat_cnt <= '0;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      if (advance) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end

      if (state == S_CAPTURE) begin
        cur_addr <= rd_addr;
        cur_data <= rd_data;
      end

`ifdef RAM_SCAN_REFRESH_ON_WRITE_EN
      if (state == S_HOLD) begin
        pending <= 1'b0;
      end else if (addr_match) begin
        pending <= 1'b1;
      end
`else
      pending <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ram_read_scanner.sv
// tb/tb_ram_read_scanner.sv - randomized bench for ram_read_scanner against an event-time reference model
module tb_ram_read_scanner;

  localparam int AW = 5;
  localparam int DW = 3;
  localparam int TD = 4;
  localparam int RL = 2;
  localparam int NA = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          step;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic          data_valid;
  logic          wrapped;

  always #5 clk = ~clk;

  ram_read_scanner #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TICK_DIV(TD),
    .RD_LAT  (RL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .step      (step),
    .wren      (wren),
    .wraddress (wraddress),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cur_addr  (cur_addr),
    .cur_data  (cur_data),
    .data_valid(data_valid),
    .wrapped   (wrapped)
  );

  // Environment RAM: two-stage registered read, updated #1 after each edge.
  logic [DW-1:0] mem [NA];
  logic [DW-1:0] r1, r2;
  assign rd_data = r2;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model in event time: s is the edge at which the current read started.
  int e, s, m_addr, m_cnt, m_pending, snap;
  int exp_valid, exp_wrap, exp_cur_addr, exp_cur_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, e);
  endtask

  task automatic model_edge(input logic rn, input logic en, input logic st,
                            input logic wr, input logic [AW-1:0] wa);
    logic tk, match;
    e++;
    exp_valid = 0;
    exp_wrap  = 0;
    if (!rn) begin
      s = e; m_addr = 0; m_cnt = 0; m_pending = 0;
      exp_cur_addr = 0; exp_cur_data = 0;
      return;
    end
    tk = en && (m_cnt == TD - 1);
    if (en) m_cnt = (m_cnt + 1) % TD;
`ifdef RAM_SCAN_REFRESH_ON_WRITE_EN
    match = wr && (int'(wa) == m_addr);
`else
    match = 1'b0;
`endif
    if (e == s + RL - 1) snap = int'(mem[m_addr]);
    if (e <= s + RL + 1) begin
      if (match) m_pending = 1;
      if (e == s + RL + 1) begin
        exp_valid = 1;
        exp_cur_addr = m_addr;
        exp_cur_data = snap;
      end
    end else if (tk || st) begin
      if (m_addr == NA - 1) exp_wrap = 1;
      m_addr = (m_addr + 1) % NA;
      s = e;
      m_pending = 0;
    end else if (m_pending || match) begin
      s = e;
      m_pending = 0;
    end
  endtask

  task automatic do_cycle(input logic rn, input logic en, input logic st,
                          input logic wr, input logic [AW-1:0] wa);
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
    reset_n = rn; enable = en; step = st; wren = wr; wraddress = wa;
    wd = DW'($urandom_range(0, 7));
    ra = rd_addr;
    model_edge(rn, en, st, wr, wa);
    @(posedge clk);
    #1;
    r2 = r1;
    r1 = mem[ra];
    if (wr) mem[wa] = wd;
    check_eq("rd_addr", 32'(rd_addr), 32'(m_addr));
    check_eq("data_valid", 32'(data_valid), 32'(exp_valid));
    check_eq("wrapped", 32'(wrapped), 32'(exp_wrap));
    check_eq("cur_addr", 32'(cur_addr), 32'(exp_cur_addr));
    check_eq("cur_data", 32'(cur_data), 32'(exp_cur_data));
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) do_cycle(1'b1, en, 1'b0, 1'b0, '0);
  endtask

  initial begin
    for (int i = 0; i < NA; i++) mem[i] = DW'(i % 8);
    r1 = '0; r2 = '0;
    e = 0; s = 0; m_addr = 0; m_cnt = 0; m_pending = 0; snap = 0;
    exp_valid = 0; exp_wrap = 0; exp_cur_addr = 0; exp_cur_data = 0;
    reset_n = 1'b0; enable = 1'b0; step = 1'b0; wren = 1'b0; wraddress = '0;

    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Free run across a full wrap.
    idle(200, 1'b1);

    // Single steps with the tick frozen.
    idle(10, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(20, 1'b0);

    // Steps every cycle: those landing in wait/capture are dropped.
    for (int i = 0; i < 100; i++) do_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(10, 1'b0);

    // Steps on top of running ticks.
    for (int i = 0; i < 200; i++)
      do_cycle(1'b1, 1'b1, ($urandom_range(0, 3) == 0), 1'b0, '0);

    // Writes hitting and missing the displayed word, in hold and mid-wait.
    idle(10, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, AW'(m_addr));
    idle(10, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, AW'(m_addr + 1));
    idle(10, 1'b0);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b1, AW'(m_addr));
    idle(12, 1'b0);

    // Reset in the middle of a wait.
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(10, 1'b0);

    // Fully random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic rn, en, st, wr;
      logic [AW-1:0] wa;
      rn = ($urandom_range(0, 299) != 0);
      en = ($urandom_range(0, 9) < 7);
      st = ($urandom_range(0, 7) == 0);
      wr = ($urandom_range(0, 3) == 0);
      wa = ($urandom_range(0, 1) == 0) ? AW'(m_addr) : AW'($urandom_range(0, NA - 1));
      do_cycle(rn, en, st, wr, wa);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
